scl180_sparecell_bank: RTL and testbench
========================================

# scl180_sparecell_bank

Parametrised spare-cell bank for the SCL180 chip top: NUM_CELLS independent spare-logic cells, each with tie-low/tie-high outputs, a spare NAND→NOR→INV chain, and a spare flop for metal-only ECOs. A built-in self-test sequencer toggles every cell's chain through its flop and records per-cell mismatches, so post-silicon debug can confirm a spare bank is functional before an ECO uses it. It is instantiated in the chip top's spare-cell area, one or more per power domain.

## Interface
- NUM_CELLS, 4: number of spare cells; legal range 1..32.
- TEST_CYCLES, 16: length of the RUN phase in clock cycles; legal range 2..256.
- wb_clk_i  input  1  single clock for the whole block.
- wb_rst_i  input  1  reset; asynchronous, active-high.
- VPWR, VGND  input  1 each  power pins, present only under USE_POWER_PIN.
- test_start_i  input  1  self-test request; sampled only in IDLE.
- inject_i  input  NUM_CELLS  fault injection; bit i inverts cell i's chain output during RUN.
- test_busy_o  output  1  high in RUN and CHECK.
- test_done_o  output  1  one-cycle pulse in DONE.
- test_pass_o  output  1  high when the last test had no failing cell; held until the next start.
- fail_map_o  output  NUM_CELLS  sticky per-cell failure bits from the last test.
- LO  output  NUM_CELLS  constant 0 per cell (tie-low); unaffected by reset.
- HI  output  NUM_CELLS  constant 1 per cell (tie-high); unaffected by reset.

## Operation
- Cell i chain: nand(x,x) → nor(n,n) → inv, giving chain_i = ~x_i. With inject_i[i] set, chain_i = x_i. Outside RUN, x_i = LO[i] (0). The chain and all tie cells stay instantiated regardless of test activity.
- Cell i spare flop: q_i <= chain_i on every clock edge. Reset value is 0.
- Stimulus in RUN: x_i = cnt[0] ^ (i & 1), where cnt is the RUN cycle counter. This gives an alternating pattern, and adjacent cells run in opposite phase.
- Expected value: exp_i = ~x_i registered one cycle earlier. In IDLE, CHECK and DONE, x_i is forced to 0.
- FSM states are IDLE, RUN, CHECK and DONE. Reset state is IDLE.
  - IDLE → RUN when test_start_i = 1. On that edge: cnt ← 0, fail_map ← 0, test_pass_o ← 0.
  - RUN: cnt increments each cycle. When cnt = 1..TEST_CYCLES-1, fail_map[i] |= (q_i != exp_i). When cnt = TEST_CYCLES-1, go to CHECK.
  - CHECK: one cycle. It performs the final compare of the last RUN sample (same rule), then goes to DONE.
  - DONE: one cycle. test_done_o = 1 and test_pass_o ← ~|fail_map. Next state is IDLE.
- test_start_i is ignored in RUN, CHECK and DONE; it is not queued.
- inject_i is only effective in RUN.
- Counter width is $clog2(TEST_CYCLES)+1 bits. There is no wrap within a run.

## Timing
- Reset values: test_busy_o = 0, test_done_o = 0, test_pass_o = 0, fail_map_o = 0, all q_i = 0, FSM = IDLE. LO = 0 and HI = 1 at all times.
- Start sampled at edge E0 → test_busy_o is high from E0 up to E0+TEST_CYCLES+1.
- test_done_o and the final test_pass_o are valid after edge E0+TEST_CYCLES+1. test_done_o is high for exactly one cycle.
- Back-to-back start: test_start_i held high through DONE starts a new test on the edge leaving IDLE, i.e. the first IDLE cycle after DONE.
- Reset asserted mid-test: immediate return to reset values, with no done pulse. Results from any previous test are cleared.
- All outputs are registered except the combinational constants LO and HI.

## Test plan
- Reset, then idle for 10 cycles → LO = 0, HI = all-ones, busy/done/pass = 0, fail_map = 0.
- NUM_CELLS = 4, TEST_CYCLES = 16, pulse start at E0, inject = 0 → busy for 17 cycles, done pulse after E0+17, pass = 1, fail_map = 4'b0000.
- inject = 4'b0100 for the whole RUN → pass = 0, fail_map = 4'b0100. A following clean test with inject = 0 → pass = 1, fail_map = 0.
- inject[0] pulsed for one cycle at cnt = 5 → fail_map = 4'b0001. This confirms the failure bit is sticky.
- Assert wb_rst_i asynchronously at cnt = 7 → busy drops without waiting for a clock edge, no done pulse, state = IDLE. A subsequent start completes normally.
- Hold start high continuously → done pulses every TEST_CYCLES+3 cycles, and starts during RUN/CHECK/DONE are ignored. Repeat with NUM_CELLS = 1, TEST_CYCLES = 2 for the boundary case.

Source files
------------

// File: rtl/scl180_sparecell_bank.sv
// rtl/scl180_sparecell_bank.sv - spare-cell bank with chain/flop self-test sequencer
module scl180_sparecell_bank #(
    parameter int NUM_CELLS   = 4,
    parameter int TEST_CYCLES = 16
) (
`ifdef USE_POWER_PIN
    input  logic                 VPWR,
    input  logic                 VGND,
`endif
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 test_start_i,
    input  logic [NUM_CELLS-1:0] inject_i,
    output logic                 test_busy_o,
    output logic                 test_done_o,
    output logic                 test_pass_o,
    output logic [NUM_CELLS-1:0] fail_map_o,
    output logic [NUM_CELLS-1:0] LO,
    output logic [NUM_CELLS-1:0] HI
);

    localparam int             CW   = $clog2(TEST_CYCLES) + 1;
    localparam logic [CW-1:0]  LAST = CW'(TEST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_CELLS-1:0] fail_q, fail_d;
    logic                 pass_q, pass_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NUM_CELLS-1:0] q_q, q_d;
    logic [NUM_CELLS-1:0] exp_q, exp_d;

    logic                 in_run;
    logic [NUM_CELLS-1:0] x;
    logic [NUM_CELLS-1:0] nand_n;
    logic [NUM_CELLS-1:0] nor_n;
    logic [NUM_CELLS-1:0] chain;
    logic [NUM_CELLS-1:0] mismatch;

    assign LO = '0;
    assign HI = '1;

    assign in_run = (state_q == S_RUN);

    // Per-cell spare chain: stimulus is the tie-low cell outside RUN, alternating pattern inside
    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
        localparam logic PHASE = ((gi % 2) == 1);
        assign x[gi]      = in_run ? (cnt_q[0] ^ PHASE) : LO[gi];
        assign nand_n[gi] = ~(x[gi] & x[gi]);
        assign nor_n[gi]  = ~(nand_n[gi] | nand_n[gi]);
        assign chain[gi]  = ~nor_n[gi] ^ (in_run & inject_i[gi]);
    end

    // Spare flops capture the chain; the expected value tracks the fault-free chain
    always_comb begin
        q_d      = chain;
        exp_d    = ~x;
        mismatch = q_q ^ exp_q;
    end

    // Sequencer next-state and result bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (test_start_i) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q != '0) begin
                    fail_d = fail_q | mismatch;
                end
                if (cnt_q == LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Last RUN sample is compared here; pass is published on entry to DONE
                fail_d  = fail_q | mismatch;
                pass_d  = ~|(fail_q | mismatch);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_CHECK);
    end

    // State and output registers, cleared immediately on reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            exp_q   <= exp_d;
        end
    end

    assign test_busy_o = busy_q;
    assign test_done_o = done_q;
    assign test_pass_o = pass_q;
    assign fail_map_o  = fail_q;

endmodule

// File: tb/tb_scl180_sparecell_bank.sv
// tb/tb_scl180_sparecell_bank.sv - self-checking bench for scl180_sparecell_bank
module tb_scl180_sparecell_bank;

    localparam int NA = 4;
    localparam int TA = 16;
    localparam int NB = 1;
    localparam int TB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_a = 1'b0;
    logic          start_b = 1'b0;
    logic [NA-1:0] inj_a = '0;
    logic [NB-1:0] inj_b = '0;

    logic          busy_a, done_a, pass_a;
    logic [NA-1:0] fail_a, lo_a, hi_a;
    logic          busy_b, done_b, pass_b;
    logic [NB-1:0] fail_b, lo_b, hi_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scl180_sparecell_bank #(.NUM_CELLS(NA), .TEST_CYCLES(TA)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .test_start_i(start_a), .inject_i(inj_a),
        .test_busy_o(busy_a), .test_done_o(done_a), .test_pass_o(pass_a),
        .fail_map_o(fail_a), .LO(lo_a), .HI(hi_a)
    );

    scl180_sparecell_bank #(.NUM_CELLS(NB), .TEST_CYCLES(TB)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .test_start_i(start_b), .inject_i(inj_b),
        .test_busy_o(busy_b), .test_done_o(done_b), .test_pass_o(pass_b),
        .fail_map_o(fail_b), .LO(lo_b), .HI(hi_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Model: position within a test measured in clock edges since the accepted start.
    // 0 = idle, 1..T = RUN cycles, T+1 = CHECK, T+2 = DONE. A cell fails iff its inject
    // bit was seen high in any RUN cycle.
    int          mk[2];
    logic [31:0] mfail[2];
    logic        mpass[2];
    int          tcyc[2];
    logic        m_s;
    logic [31:0] m_inj;

    initial begin
        tcyc[0] = TA;
        tcyc[1] = TB;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mk[i]    = 0;
                mfail[i] = 0;
                mpass[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_s   = (i == 0) ? start_a : start_b;
                m_inj = (i == 0) ? 32'(inj_a) : 32'(inj_b);
                if (mk[i] == 0) begin
                    if (m_s) begin
                        mk[i]    = 1;
                        mfail[i] = 0;
                        mpass[i] = 1'b0;
                    end
                end else begin
                    if (mk[i] <= tcyc[i]) mfail[i] = mfail[i] | m_inj;
                    mk[i] = mk[i] + 1;
                    if (mk[i] == tcyc[i] + 2) mpass[i] = (mfail[i] == 0);
                    else if (mk[i] > tcyc[i] + 2) mk[i] = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(posedge clk) begin
        #2;
        chk("lo_a", 32'(lo_a), 32'h0);
        chk("hi_a", 32'(hi_a), 32'hF);
        chk("lo_b", 32'(lo_b), 32'h0);
        chk("hi_b", 32'(hi_b), 32'h1);
        chk("busy_a", 32'(busy_a), 32'((mk[0] >= 1) && (mk[0] <= TA + 1)));
        chk("done_a", 32'(done_a), 32'(mk[0] == TA + 2));
        chk("pass_a", 32'(pass_a), 32'(mpass[0]));
        if (mk[0] == 0 || mk[0] == TA + 2) chk("fail_map_a", 32'(fail_a), mfail[0]);
        chk("busy_b", 32'(busy_b), 32'((mk[1] >= 1) && (mk[1] <= TB + 1)));
        chk("done_b", 32'(done_b), 32'(mk[1] == TB + 2));
        chk("pass_b", 32'(pass_b), 32'(mpass[1]));
        if (mk[1] == 0 || mk[1] == TB + 2) chk("fail_map_b", 32'(fail_b), mfail[1]);
    end

    function automatic logic cur_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    function automatic logic cur_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic [31:0] cur_fail(input int sel);
        return (sel == 0) ? 32'(fail_a) : 32'(fail_b);
    endfunction

    function automatic logic cur_pass(input int sel);
        return (sel == 0) ? pass_a : pass_b;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    task automatic set_inj(input int sel, input logic [31:0] v);
        if (sel == 0) inj_a = v[NA-1:0];
        else          inj_b = v[NB-1:0];
    endtask

    // Wait (bounded) for done; returns number of busy cycles seen on the way
    task automatic wait_done(input int sel, output int nbusy);
        int c;
        nbusy = 0;
        c     = 0;
        while (!cur_done(sel) && c < 300) begin
            if (cur_busy(sel)) nbusy++;
            @(negedge clk);
            c++;
        end
        chk("done_reached", 32'(cur_done(sel)), 32'h1);
    endtask

    task automatic run_test(input int sel, input int t, input logic [31:0] inj,
                            input logic [31:0] exp_fail, input logic exp_pass);
        int nb;
        @(negedge clk);
        set_start(sel, 1'b1);
        set_inj(sel, inj);
        @(negedge clk);
        set_start(sel, 1'b0);
        wait_done(sel, nb);
        chk("busy_len", 32'(nb), 32'(t + 1));
        chk("fail_map_lit", cur_fail(sel), exp_fail);
        chk("pass_lit", 32'(cur_pass(sel)), 32'(exp_pass));
        set_inj(sel, 32'h0);
        @(negedge clk);
        chk("done_one_cycle", 32'(cur_done(sel)), 32'h0);
    endtask

    task automatic hold_test(input int sel, input int t);
        int first, last, n, prev;
        n = 0; prev = -1; first = -1; last = -1;
        @(negedge clk);
        set_start(sel, 1'b1);
        for (int c = 0; c < 4 * t + 10; c++) begin
            @(negedge clk);
            if (cur_done(sel)) begin
                if (prev >= 0) chk("done_period", 32'(c - prev), 32'(t + 3));
                if (first < 0) first = c;
                prev = c;
                last = c;
                n++;
            end
        end
        set_start(sel, 1'b0);
        chk("done_count", 32'(n), 32'd3);
        chk("done_first", 32'(first), 32'(t + 1));
        chk("done_span", 32'(last - first), 32'(2 * (t + 3)));
        repeat (t + 6) @(negedge clk);
    endtask

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_lo", 32'(lo_a), 32'h0);
        chk("rst_hi", 32'(hi_a), 32'hF);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_pass", 32'(pass_a), 32'h0);
        chk("rst_fail", 32'(fail_a), 32'h0);

        run_test(0, TA, 32'h0, 32'h0, 1'b1);
        run_test(0, TA, 32'h4, 32'h4, 1'b0);
        run_test(0, TA, 32'h0, 32'h0, 1'b1);

        // one-cycle injection on cell 0 at cnt = 5
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        inj_a = 4'b0001;
        @(negedge clk);
        inj_a = 4'b0000;
        wait_done(0, nb);
        chk("pulse_fail_map", 32'(fail_a), 32'h1);
        chk("pulse_pass", 32'(pass_a), 32'h0);
        repeat (2) @(negedge clk);

        // asynchronous reset at cnt = 7
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_busy", 32'(busy_a), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy_a), 32'h0);
        chk("async_done", 32'(done_a), 32'h0);
        chk("async_fail", 32'(fail_a), 32'h0);
        chk("async_pass", 32'(pass_a), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_test(0, TA, 32'h0, 32'h0, 1'b1);

        hold_test(0, TA);

        run_test(1, TB, 32'h0, 32'h0, 1'b1);
        run_test(1, TB, 32'h1, 32'h1, 1'b0);
        run_test(1, TB, 32'h0, 32'h0, 1'b1);
        hold_test(1, TB);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
